// File: rtl/i2c_slave_top.sv
// WISHBONE-attached I2C slave: matches its own 7-bit address, receives bytes
// into RXR, transmits from TXR and stretches SCL while no byte is pending.
module i2c_slave_top #(
  parameter logic [6:0] DEF_SADR = 7'h50
) (
  input  logic       wb_clk_i,
  input  logic       rst_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       wb_inta_o,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       scl_pad_o,
  output logic       sda_pad_o,
  output logic       scl_padoen_o,
  output logic       sda_padoen_o
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, STRETCH, WAIT_STOP
  } state_t;

  state_t     state, state_n;
  logic [6:0] sadr;
  logic       en, ien, nak;
  logic [7:0] txr, rxr, sh, sh_n, rd_mux, sr;
  logic       rxack, busy, aas, rw, sto, rxf, txe, irq;
  logic [2:0] cnt, cnt_n, scl_q, sda_q;
  logic       sda_oen, sda_n, scl_oen, scl_n;
  logic       ack_on, ack_on_n, ack_nak, ack_nak_n;
  logic       irq_set, aas_set, rw_ld, rxr_ld, rxack_ld, txe_set, stretch_ld;
  logic       scl_s, scl_d, sda_s, sda_d, scl_rise, scl_fall, start, stop;
  logic       acc, wr, rd, txr_wr, cr_wr, iack;

  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = scl_oen;
  assign sda_padoen_o = sda_oen;

  // q[0],q[1] synchronize; q[2] is the delayed copy for edge detection
  assign scl_s    = scl_q[1];
  assign scl_d    = scl_q[2];
  assign sda_s    = sda_q[1];
  assign sda_d    = sda_q[2];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & ~sda_s & sda_d;
  assign stop     = scl_s & sda_s & ~sda_d;

  assign acc    = wb_cyc_i & wb_stb_i;
  assign wr     = wb_ack_o & wb_we_i;
  assign rd     = wb_ack_o & ~wb_we_i;
  assign txr_wr = wr & (wb_adr_i == 2'd2);
  assign cr_wr  = wr & (wb_adr_i == 2'd3);
  assign iack   = cr_wr & wb_dat_i[0];
  assign sr     = {rxack, busy, aas, rw, sto, rxf, txe, irq};

  always_comb begin
    case (wb_adr_i)
      2'd0:    rd_mux = {1'b0, sadr};
      2'd1:    rd_mux = {en, ien, 6'b0};
      2'd2:    rd_mux = rxr;
      default: rd_mux = sr;
    endcase
  end

  always_comb begin
    state_n = state;  cnt_n = cnt;  sh_n = sh;
    sda_n = sda_oen;  scl_n = 1'b1;
    ack_on_n = ack_on;  ack_nak_n = ack_nak;
    irq_set = 1'b0;  aas_set = 1'b0;  rw_ld = 1'b0;  rxr_ld = 1'b0;
    rxack_ld = 1'b0;  txe_set = 1'b0;  stretch_ld = 1'b0;
    if (!en) begin
      state_n = IDLE;  sda_n = 1'b1;  ack_on_n = 1'b0;
    end else if (start) begin
      state_n = ADDR;  cnt_n = '0;  sda_n = 1'b1;  ack_on_n = 1'b0;
    end else if (stop) begin
      state_n = IDLE;  sda_n = 1'b1;  ack_on_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_n  = {sh[6:0], sda_s};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (sh[6:0] == sadr) begin
              aas_set = 1'b1;  rw_ld = 1'b1;  irq_set = 1'b1;  state_n = ADDR_ACK;
            end else state_n = WAIT_STOP;
          end
        end
        // first falling edge drives the ack bit, second one releases it
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          ack_on_n = ~ack_on;
          if (!ack_on) sda_n = (state == RX_ACK) & ack_nak;
          else begin
            sda_n = 1'b1;
            if (state == RX_ACK && ack_nak) state_n = WAIT_STOP;
            else if (!rw) begin
              state_n = RX;  cnt_n = '0;
            end else if (!txe) begin
              state_n = TX;  cnt_n = '0;  sh_n = txr;  sda_n = txr[7];  txe_set = 1'b1;
            end else begin
              state_n = STRETCH;  scl_n = 1'b0;
            end
          end
        end
        RX: if (scl_rise) begin
          sh_n  = {sh[6:0], sda_s};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            state_n   = RX_ACK;
            ack_nak_n = rxf | nak;
            if (!rxf && !nak) begin
              rxr_ld = 1'b1;  irq_set = 1'b1;
            end
          end
        end
        TX: if (scl_fall) begin
          if (cnt == 3'd7) begin
            sda_n = 1'b1;  state_n = TX_ACK;
          end else begin
            sh_n = {sh[6:0], 1'b0};  sda_n = sh[6];  cnt_n = cnt + 3'd1;
          end
        end
        TX_ACK: if (scl_rise) begin
          rxack_ld = 1'b1;  irq_set = 1'b1;  ack_on_n = 1'b1;
        end else if (scl_fall && ack_on) begin
          ack_on_n = 1'b0;
          if (rxack) state_n = WAIT_STOP;
          else if (!txe) begin
            state_n = TX;  cnt_n = '0;  sh_n = txr;  sda_n = txr[7];  txe_set = 1'b1;
          end else begin
            state_n = STRETCH;  scl_n = 1'b0;
          end
        end
        // SCL stays low for the write cycle; it is released one cycle after
        // SDA already carries bit 7
        STRETCH: begin
          scl_n = 1'b0;
          if (txr_wr) begin
            state_n = TX;  cnt_n = '0;  sh_n = wb_dat_i;  sda_n = wb_dat_i[7];
            stretch_ld = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;  cnt <= '0;  sh <= '0;
      sda_oen <= 1'b1;  scl_oen <= 1'b1;  ack_on <= 1'b0;  ack_nak <= 1'b0;
      scl_q <= 3'b111;  sda_q <= 3'b111;
    end else begin
      state <= state_n;  cnt <= cnt_n;  sh <= sh_n;
      sda_oen <= sda_n;  scl_oen <= scl_n;  ack_on <= ack_on_n;  ack_nak <= ack_nak_n;
      scl_q <= {scl_q[1:0], scl_pad_i};
      sda_q <= {sda_q[1:0], sda_pad_i};
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_ack_o <= 1'b0;  wb_dat_o <= '0;  wb_inta_o <= 1'b0;
      sadr <= DEF_SADR;  en <= 1'b0;  ien <= 1'b0;  nak <= 1'b0;
      txr <= '0;  rxr <= '0;
      rxack <= 1'b0;  busy <= 1'b0;  aas <= 1'b0;  rw <= 1'b0;
      sto <= 1'b0;  rxf <= 1'b0;  txe <= 1'b1;  irq <= 1'b0;
    end else begin
      wb_ack_o <= acc & ~wb_ack_o;
      if (acc && !wb_ack_o) wb_dat_o <= rd_mux;
      if (wr && wb_adr_i == 2'd0) sadr <= wb_dat_i[6:0];
      if (wr && wb_adr_i == 2'd1) {en, ien} <= wb_dat_i[7:6];
      if (txr_wr) txr <= wb_dat_i;
      if (cr_wr) nak <= wb_dat_i[3];
      if (txr_wr) txe <= stretch_ld;
      else if (txe_set) txe <= 1'b1;
      if (rxr_ld) begin
        rxr <= sh_n;  rxf <= 1'b1;
      end else if (rd && wb_adr_i == 2'd2) rxf <= 1'b0;
      if (rxack_ld) rxack <= sda_s;
      if (start) busy <= 1'b1;
      else if (stop) busy <= 1'b0;
      if (aas_set) aas <= 1'b1;
      else if (start || !en) aas <= 1'b0;
      if (rw_ld) rw <= sda_s;
      if (stop && aas) sto <= 1'b1;
      else if (iack) sto <= 1'b0;
      if (irq_set) irq <= 1'b1;
      else if (iack) irq <= 1'b0;
      wb_inta_o <= irq & ien;
    end
  end
endmodule

// File: tb/tb_i2c_slave_top.sv
// Directed bench: a bit-banged I2C master plus WISHBONE host; expected values
// are queued at issue time and checked by a separate monitor.
module tb_i2c_slave_top;
  localparam int Q = 10;

  logic       wb_clk_i = 1'b0, rst_i = 1'b0;
  logic [1:0] wb_adr_i = '0;
  logic [7:0] wb_dat_i = '0, wb_dat_o;
  logic       wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_ack_o, wb_inta_o;
  logic       scl_pad_o, sda_pad_o, scl_padoen_o, sda_padoen_o;
  logic       scl_m = 1'b1, sda_m = 1'b1, scl_line, sda_line;

  assign scl_line = scl_m & scl_padoen_o;
  assign sda_line = sda_m & sda_padoen_o;

  i2c_slave_top #(.DEF_SADR(7'h50)) dut (
    .wb_clk_i(wb_clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_inta_o(wb_inta_o), .scl_pad_i(scl_line), .sda_pad_i(sda_line),
    .scl_pad_o(scl_pad_o), .sda_pad_o(sda_pad_o),
    .scl_padoen_o(scl_padoen_o), .sda_padoen_o(sda_padoen_o));

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;
  exp_t       q[$];
  int         rd_idx = 0, total = 0, bad = 0, pad_low_cnt = 0;
  logic       obs_vld = 1'b0, done = 1'b0;
  logic [7:0] obs_val = '0;

  always @(posedge wb_clk_i)
    if (!scl_padoen_o || !sda_padoen_o) pad_low_cnt <= pad_low_cnt + 1;

  task automatic cmp(input logic [7:0] v);
    total++;
    if (rd_idx >= q.size()) begin
      bad++;
      $display("FAIL unexpected_output: got %02h, nothing expected", v);
    end else begin
      if (v !== q[rd_idx].val) begin
        bad++;
        $display("FAIL %s: got %02h want %02h", q[rd_idx].name, v, q[rd_idx].val);
      end
      rd_idx++;
    end
  endtask

  // monitor: read-data on each read ack, bus-side observations on obs_vld
  always @(negedge wb_clk_i) begin
    if (wb_ack_o && !wb_we_i) cmp(wb_dat_o);
    if (obs_vld) cmp(obs_val);
    if (done) begin
      while (rd_idx < q.size()) begin
        total++;  bad++;
        $display("FAIL %s: no output observed", q[rd_idx].name);
        rd_idx++;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic push(input string nm, input logic [7:0] e);
    exp_t x;
    x.name = nm;  x.val = e;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [7:0] v, input logic [7:0] e);
    push(nm, e);
    obs_val = v;  obs_vld = 1'b1;
    @(negedge wb_clk_i);
    #1 obs_vld = 1'b0;
  endtask

  task automatic wb_cycle(input logic we, input logic [1:0] a, input logic [7:0] d);
    int n = 0;
    wb_cyc_i = 1'b1;  wb_stb_i = 1'b1;  wb_we_i = we;  wb_adr_i = a;  wb_dat_i = d;
    @(negedge wb_clk_i);
    while (!wb_ack_o && n < 20) begin @(negedge wb_clk_i); n++; end
    @(posedge wb_clk_i);
    #1 wb_cyc_i = 1'b0;  wb_stb_i = 1'b0;  wb_we_i = 1'b0;
    if (n >= 20) chk("wb_ack_timeout", {7'b0, wb_ack_o}, 8'h01);
  endtask

  task automatic wb_read(input logic [1:0] a, input string nm, input logic [7:0] e);
    push(nm, e);
    wb_cycle(1'b0, a, 8'h00);
  endtask

  task automatic scl_up();
    int n = 0;
    scl_m = 1'b1;
    while (!scl_line && n < 4000) begin tick(1); n++; end
    if (n >= 4000) chk("scl_stuck_low", {7'b0, scl_line}, 8'h01);
  endtask

  task automatic wbit(input logic b);
    sda_m = b;  tick(Q);  scl_up();  tick(2 * Q);  scl_m = 1'b0;  tick(Q);
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1;  tick(Q);  scl_up();  tick(Q);  b = sda_line;  tick(Q);
    scl_m = 1'b0;  tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;  tick(Q);  scl_up();  tick(Q);  sda_m = 1'b0;  tick(Q);
    scl_m = 1'b0;  tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;  tick(Q);  scl_up();  tick(Q);  sda_m = 1'b1;  tick(Q);
  endtask

  task automatic wbyte(input string nm, input logic [7:0] d, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    chk(nm, {7'b0, a}, {7'b0, exp_ack});
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin rbit(b); d[i] = b; end
    wbit(nack);
  endtask

  initial begin
    logic [7:0] d;
    logic       sclr;
    int         pc;
    tick(4);
    chk("rst_ctl", {wb_ack_o, wb_inta_o, 4'b0, scl_padoen_o, sda_padoen_o}, 8'h03);
    chk("rst_dat", wb_dat_o, 8'h00);
    rst_i = 1'b1;  tick(2);
    wb_read(2'd3, "sr_rst", 8'h02);
    wb_read(2'd0, "sadr_rst", 8'h50);
    wb_read(2'd1, "ctr_rst", 8'h00);
    wb_cycle(1'b1, 2'd1, 8'hC0);
    wb_read(2'd1, "ctr_en", 8'hC0);

    // master write, then a byte that overflows RXR
    i2c_start();
    wbyte("w_addr_ack", 8'hA0, 1'b0);
    wbyte("w_data_ack", 8'h3C, 1'b0);
    wb_read(2'd3, "sr_after_rx", 8'h67);
    chk("inta_rx", {7'b0, wb_inta_o}, 8'h01);
    wbyte("w_ovf_nack", 8'h55, 1'b1);
    i2c_stop();
    wb_read(2'd3, "sr_after_stop", 8'h2F);
    wb_read(2'd2, "rxr", 8'h3C);
    wb_cycle(1'b1, 2'd3, 8'h01);
    wb_read(2'd3, "sr_after_iack", 8'h22);

    // foreign address: no pad activity at all
    pc = pad_low_cnt;
    i2c_start();
    wbyte("mis_addr_nack", 8'hB0, 1'b1);
    wbyte("mis_data_nack", 8'h12, 1'b1);
    i2c_stop();
    chk("mis_pad_quiet", 8'(pad_low_cnt - pc), 8'h00);
    wb_read(2'd3, "sr_mis", 8'h02);

    // master read of a preloaded byte, master NACK
    wb_cycle(1'b1, 2'd2, 8'h96);
    i2c_start();
    wbyte("r_addr_ack", 8'hA1, 1'b0);
    rbyte(1'b1, d);
    chk("r_data", d, 8'h96);
    chk("r_sda_rel", {7'b0, sda_padoen_o}, 8'h01);
    wb_read(2'd3, "sr_r_nack", 8'hF3);
    i2c_stop();
    wb_read(2'd3, "sr_r_stop", 8'hBB);
    wb_cycle(1'b1, 2'd3, 8'h01);
    wb_read(2'd3, "sr_r_iack", 8'hB2);

    // read with nothing pending: SCL held until TXR is written
    i2c_start();
    wbyte("s_addr_ack", 8'hA1, 1'b0);
    tick(20);
    chk("s_scl_held", {7'b0, scl_padoen_o}, 8'h00);
    wb_read(2'd3, "sr_stretch", 8'hF3);
    sclr = 1'b0;
    fork
      rbyte(1'b0, d);
      begin
        tick(10);
        wb_cycle(1'b1, 2'd2, 8'h5A);
        tick(1);
        sclr = scl_padoen_o;
      end
    join
    chk("s_scl_rel", {7'b0, sclr}, 8'h01);
    chk("s_data", d, 8'h5A);
    tick(20);
    chk("s_scl_held2", {7'b0, scl_padoen_o}, 8'h00);

    // asynchronous reset while stretching
    @(negedge wb_clk_i);
    #2 rst_i = 1'b0;
    #1 chk("rst_pads_async", {6'b0, scl_padoen_o, sda_padoen_o}, 8'h03);
    tick(3);
    rst_i = 1'b1;  tick(1);
    wb_read(2'd3, "sr_rst2", 8'h02);
    i2c_stop();
    wb_read(2'd1, "ctr_rst2", 8'h00);

    // write then repeated START into read
    wb_cycle(1'b1, 2'd1, 8'hC0);
    wb_cycle(1'b1, 2'd2, 8'hC3);
    i2c_start();
    wbyte("rs_addr_w_ack", 8'hA0, 1'b0);
    wbyte("rs_data_ack", 8'h01, 1'b0);
    i2c_start();
    wbyte("rs_addr_r_ack", 8'hA1, 1'b0);
    wb_read(2'd3, "sr_rs", 8'h77);
    rbyte(1'b1, d);
    chk("rs_data", d, 8'hC3);
    i2c_stop();
    wb_read(2'd3, "sr_rs_stop", 8'hBF);
    wb_cycle(1'b1, 2'd3, 8'h01);
    wb_read(2'd3, "sr_rs_iack", 8'hB6);
    tick(2);
    chk("inta_cleared", {7'b0, wb_inta_o}, 8'h00);
    wb_read(2'd2, "rxr_rs", 8'h01);
    wb_read(2'd3, "sr_rs_rd", 8'hB2);

    // NAK bit refuses data even with RXR empty
    wb_cycle(1'b1, 2'd3, 8'h08);
    i2c_start();
    wbyte("nak_addr_ack", 8'hA0, 1'b0);
    wbyte("nak_data_nack", 8'h77, 1'b1);
    i2c_stop();
    wb_read(2'd3, "sr_nak", 8'hAB);
    chk("inta_nak", {7'b0, wb_inta_o}, 8'h01);
    wb_cycle(1'b1, 2'd3, 8'h01);
    wb_read(2'd3, "sr_nak_iack", 8'hA2);

    for (int i = 0; i < 100 && rd_idx < q.size(); i++) tick(1);
    done = 1'b1;
  end
endmodule

// File: doc/i2c_slave_top.md
I2C_SLAVE_TOP -- requirements
Module: i2c_slave_top

Interface
REQ-001 Parameter DEF_SADR, default 7'h50: reset value of the own-address register SADR.
REQ-002 wb_clk_i  in  1  system clock; all logic on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 wb_adr_i  in  2  register select.
REQ-005 wb_dat_i  in  8  write data.
REQ-006 wb_dat_o  out  8  read data, registered.
REQ-007 wb_we_i, wb_stb_i, wb_cyc_i  in  1 each  WISHBONE write enable, strobe, cycle.
REQ-008 wb_ack_o  out  1  bus cycle acknowledge.
REQ-009 wb_inta_o  out  1  interrupt request, registered.
REQ-010 scl_pad_i / sda_pad_i  in  1  SCL/SDA line inputs.
REQ-011 scl_pad_o / sda_pad_o  out  1  tied 1'b0.
REQ-012 scl_padoen_o / sda_padoen_o  out  1  output enables, active-low (0 = pull line low).

Function
REQ-013 wb_ack_o SHALL be registered cyc & stb & ~wb_ack_o, giving a one-wait-state ack. A write takes effect when we & wb_ack_o.
REQ-014 Register map:
  - 0: SADR[6:0], R/W.
  - 1: CTR, R/W. bit7 EN, bit6 IEN, other bits read 0.
  - 2: write TXR, read RXR.
  - 3: write CR, read SR.
REQ-015 SR bits:
  - 7 RXACK: last master ack bit, 1 = NACK.
  - 6 BUSY: START seen, STOP not yet seen.
  - 5 AAS: addressed as slave.
  - 4 RW: 1 = master reads.
  - 3 STO: STOP seen while AAS.
  - 2 RXF: RXR full.
  - 1 TXE: TXR empty.
  - 0 IRQ.
REQ-016 CR bits: bit3 NAK (1 = NACK subsequent received data bytes, sticky). bit0 IACK: write 1 clears IRQ and STO and is self-clearing.
REQ-017 Input conditioning: scl/sda pass through 2-flop synchronizers, then a 1-cycle delayed copy for edge detection. Edges, START and STOP are acted on 3 cycles after the pad change. Operation requires wb_clk_i >= 10x SCL.
REQ-018 START = SDA falling while synced SCL high. STOP = SDA rising while synced SCL high. Both are detected in every state and take priority over bit processing.
REQ-019 States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, STRETCH, WAIT_STOP. A 3-bit bit counter is cleared on START and on entry to RX/TX.
REQ-020 START (including repeated START) -> ADDR, with AAS cleared. STOP -> IDLE, BUSY cleared, and STO set if AAS was 1.
REQ-021 ADDR: sample SDA on each SCL rising edge, MSB first. After the 8th bit:
  - If bits[7:1] == SADR and EN=1: set AAS, set RW=bit0, set IRQ, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP.
REQ-022 ACK driving: on the SCL falling edge entering any *_ACK-drive phase, sda_padoen_o is driven 0 (ACK) or 1 (NACK). It is released on the next SCL falling edge.
REQ-023 After ADDR_ACK:
  - RW=0 -> RX.
  - RW=1 and TXE=0 -> TX: load shift register from TXR, set TXE.
  - RW=1 and TXE=1 -> STRETCH.
REQ-024 RX: shift 8 bits on SCL rising edges. On the 8th bit:
  - If RXF=0 and NAK=0: RXR <= byte, set RXF, set IRQ, ACK.
  - If RXF=1 or NAK=1: discard byte, NACK, then go to WAIT_STOP after the ack clock.
REQ-025 Reading RXR (address 2 read ack) SHALL clear RXF.
REQ-026 TX: drive each bit on sda_padoen_o (bit=0 -> 0, bit=1 -> 1), changing only on SCL falling edges. Release SDA after the 8th bit's falling edge.
REQ-027 TX_ACK: sample SDA on the SCL rising edge into RXACK and set IRQ. Then:
  - ACK with TXE=0 -> TX (reload from TXR).
  - ACK with TXE=1 -> STRETCH.
  - NACK -> WAIT_STOP.
REQ-028 STRETCH: after the SCL falling edge, drive scl_padoen_o = 0 until TXR is written. On that write: load the shift register, set TXE, release SCL, go to TX with bit 7 already driven on SDA before the release.
REQ-029 Writing TXR SHALL clear TXE. Writing TXR while TXE=0 overwrites the pending byte.
REQ-030 EN=0 SHALL force IDLE, release both pads and clear AAS. Registers are retained.
REQ-031 IRQ set and IACK write in the same cycle: set wins.
REQ-032 wb_inta_o <= IRQ & IEN.
REQ-033 STOP or START during STRETCH SHALL release SCL immediately.

Reset
REQ-034 On rst_i=0 the following SHALL be forced:
  - SADR=DEF_SADR, CTR=0, TXR=0, RXR=0, state IDLE.
  - SR=8'h02 (TXE=1, all other bits 0).
  - wb_dat_o=0, wb_ack_o=0, wb_inta_o=0.
  - scl_padoen_o=1, sda_padoen_o=1.
REQ-035 Reset mid-transfer SHALL release both pads in the same cycle, asynchronously.

Verification
REQ-036 Master write: EN=1, address 0xA0, then data 0x3C -> ACK on both bytes; RXR=0x3C; SR shows AAS=1, RW=0, RXF=1, IRQ=1. A second byte sent before RXR is read -> NACK, WAIT_STOP.
REQ-037 Master read with TXR=0x96 preloaded: address 0xA1 -> SDA carries 1001_0110. Master NACK -> RXACK=1, IRQ=1, SDA released.
REQ-038 Master read with TXE=1: after address ACK, SCL is held low. TXR write of 0x5A -> SCL released within 2 cycles and 0x5A is transmitted.
REQ-039 Address mismatch (0xB0 with SADR=0x50) -> no ACK, AAS=0, IRQ=0, no pad activity until STOP.
REQ-040 Repeated START: write 0xA0, 0x01, Sr, 0xA1 -> RW flips to 1 and TX starts. STOP -> STO=1, BUSY=0. IACK write -> IRQ=0, STO=0.
REQ-041 rst_i pulled low during STRETCH -> pads released immediately and SR=8'h02.
